// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command front-end for the 8-bit FunSel/ZCNO ALU.
// Accepts one request, drives the ALU for exactly one evaluation cycle, captures the
// result and flags, evaluates a branch condition and returns it on a valid/ready channel.
// While no request is executing, FunSel is held at IDLE_FUNSEL (pass A), so the C and O
// flags survive between requests.
// Optional feature: define ALU_CMD_PIPE_EN to accept a new request in the same edge that
// retires a response (RESP -> EXEC), raising throughput from 1 op/4 cycles to 1 op/3 cycles.
module alu_cmd_sequencer #(
  parameter logic [3:0] IDLE_FUNSEL = 4'b0000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [2:0] req_cond,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_funsel,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_zcno,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_flags,
  output logic       rsp_cond
);

  typedef enum logic [1:0] {StIdle, StExec, StCap, StResp} state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, b_q;
  logic [3:0] op_q;
  logic [2:0] cond_q;
  logic [7:0] rsp_data_q;
  logic [3:0] rsp_flags_q;
  logic       rsp_cond_q;
  logic       accept;
  logic       cond_eval;

  assign accept    = req_valid & req_ready;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_cond  = rsp_cond_q;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_valid) state_d = StExec;
      StExec: state_d = StCap;
      StCap:  state_d = StResp;
      StResp: begin
        if (rsp_ready) begin
`ifdef ALU_CMD_PIPE_EN
          state_d = req_valid ? StExec : StIdle;
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; the requested op reaches FunSel only during EXEC
  always_comb begin
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    alu_funsel = IDLE_FUNSEL;
    unique case (state_q)
      StIdle: req_ready = 1'b1;
      StExec: alu_funsel = op_q;
      StCap:  ;
      StResp: begin
        rsp_valid = 1'b1;
`ifdef ALU_CMD_PIPE_EN
        req_ready = rsp_ready;
`endif
      end
      default: ;
    endcase
  end

  // Branch condition from the flags being captured
  always_comb begin
    cond_eval = 1'b0;
    unique case (cond_q)
      3'b000: cond_eval = 1'b1;
      3'b001: cond_eval = alu_zcno[3];
      3'b010: cond_eval = ~alu_zcno[3];
      3'b011: cond_eval = alu_zcno[2];
      3'b100: cond_eval = ~alu_zcno[2];
      3'b101: cond_eval = alu_zcno[1];
      3'b110: cond_eval = alu_zcno[0];
      3'b111: cond_eval = alu_zcno[1] ^ alu_zcno[0];
      default: cond_eval = 1'b0;
    endcase
  end

  // Request registers and response capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      op_q        <= IDLE_FUNSEL;
      cond_q      <= 3'b000;
      rsp_data_q  <= 8'h00;
      rsp_flags_q <= 4'h0;
      rsp_cond_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q    <= req_a;
        b_q    <= req_b;
        op_q   <= req_op;
        cond_q <= req_cond;
      end
      // Flag register settled 1 ns after the EXEC edge, so it is stable here
      if (state_q == StCap) begin
        rsp_data_q  <= alu_out;
        rsp_flags_q <= alu_zcno;
        rsp_cond_q  <= cond_eval;
      end
    end
  end

endmodule
